chorus_effect: RTL and testbench

Chorus stage of the audio effects chain: once per sample, while it holds the processing turn, it reads one delayed sample from the shared delay-line RAM (`smart_ram`). The RAM address is an LFO-modulated delay. The block mixes that delayed sample 50/50 with the live input and reports completion with a one-cycle `done`. An external arbiter multiplexes its RAM read request against other clients.

---
 rtl/fx_pkg.sv | 36 +++
 rtl/chorus_lfo.sv | 53 +++++
 rtl/chorus_effect.sv | 100 ++++++++++
 tb/tb_chorus_effect.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx_pkg.sv
// ---------------------------------------------------------------------------
// fx_pkg
// Definitions shared by the audio effects chain.
//   SAMPLE_W        audio sample width (signed two's complement)
//   ADDR_W          delay-line RAM offset width
//   DEF_BASE_DELAY  default minimum chorus delay, in samples
//   DEF_DEPTH       default LFO peak excursion, in samples
//   chorus_state_e  chorus sequencing states
//   mix_half()      50/50 mix of two signed samples
// ---------------------------------------------------------------------------
package fx_pkg;

    localparam int SAMPLE_W       = 16;
    localparam int ADDR_W         = 13;
    localparam int DEF_BASE_DELAY = 1024;
    localparam int DEF_DEPTH      = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_OUT  = 2'd2
    } chorus_state_e;

    // Average of two signed samples. The sum is formed one bit wider so
    // the halving can never overflow; dropping the LSB of the 17-bit sum
    // is an arithmetic shift right by one (rounds toward minus infinity).
    function automatic logic [SAMPLE_W-1:0] mix_half(
        input logic [SAMPLE_W-1:0] a,
        input logic [SAMPLE_W-1:0] b
    );
        logic [SAMPLE_W:0] sum;
        sum = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
        return sum[SAMPLE_W:1];
    endfunction

endpackage

// File: rtl/chorus_lfo.sv
// ---------------------------------------------------------------------------
// chorus_lfo
// Triangle-wave LFO for the chorus delay modulation. Counts 0..DEPTH and
// back, moving one step per `step` pulse.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-low reset (lfo=0, direction up)
//   step  in   advance the LFO by one position
//   lfo   out  current LFO value, 0..DEPTH
// ---------------------------------------------------------------------------
module chorus_lfo
    import fx_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    output logic [ADDR_W-1:0] lfo
);

    localparam logic [ADDR_W-1:0] PEAK = ADDR_W'(DEPTH);

    logic [ADDR_W-1:0] r_lfo;
    logic              r_up;
    logic [ADDR_W-1:0] w_next;

    assign w_next = r_up ? r_lfo + 1'b1 : r_lfo - 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfo <= '0;
            r_up  <= 1'b1;
        end else if (step) begin
            if (PEAK == '0) begin
                // Zero excursion: the LFO is pinned at 0.
                r_lfo <= '0;
            end else begin
                r_lfo <= w_next;
                // Turn around as soon as an end point is reached so the
                // next step already heads back the other way.
                if (w_next == PEAK) begin
                    r_up <= 1'b0;
                end else if (w_next == '0) begin
                    r_up <= 1'b1;
                end
            end
        end
    end

    assign lfo = r_lfo;

endmodule

// File: rtl/chorus_effect.sv
// ---------------------------------------------------------------------------
// chorus_effect
// Chorus stage: per processing turn, reads one LFO-modulated delayed sample
// from the shared delay-line RAM, mixes it 50/50 with the live input and
// pulses `done` for one cycle with the result on `data_out`.
// Ports:
//   clk               in   clock, rising edge
//   rst               in   asynchronous active-low reset
//   cs                in   block enable; low blocks new operations
//   my_turn           in   arbiter grant (level)
//   data_in           in   live sample, signed, sampled with the read data
//   sram_data_in      in   delayed sample from the RAM, signed
//   sram_read_finish  in   RAM read complete, sram_data_in valid
//   sram_rd           out  RAM read request, held until the read completes
//   sram_offset       out  delay back from the newest sample (0 = newest)
//   done              out  one-cycle completion pulse
//   data_out          out  mixed sample, held between done pulses
// ---------------------------------------------------------------------------
module chorus_effect
    import fx_pkg::*;
#(
    parameter int BASE_DELAY = DEF_BASE_DELAY,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cs,
    input  logic                my_turn,
    input  logic [SAMPLE_W-1:0] data_in,
    input  logic [SAMPLE_W-1:0] sram_data_in,
    input  logic                sram_read_finish,
    output logic                sram_rd,
    output logic [ADDR_W-1:0]   sram_offset,
    output logic                done,
    output logic [SAMPLE_W-1:0] data_out
);

    chorus_state_e       r_state;
    logic                r_rd;
    logic [ADDR_W-1:0]   r_offset;
    logic                r_done;
    logic [SAMPLE_W-1:0] r_data_out;
    logic [ADDR_W-1:0]   w_lfo;

    // The LFO advances at the end of the done cycle, so the next
    // operation's offset already reflects the new position.
    chorus_lfo #(
        .DEPTH(DEPTH)
    ) u_lfo (
        .clk (clk),
        .rst (rst),
        .step(r_done),
        .lfo (w_lfo)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_rd       <= 1'b0;
            r_offset   <= '0;
            r_done     <= 1'b0;
            r_data_out <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register updates
            // from the values present before the edge, independent of order.
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cs && my_turn) begin
                        r_offset <= ADDR_W'(BASE_DELAY) + w_lfo;
                        r_rd     <= 1'b1;
                        r_state  <= ST_READ;
                    end
                end
                // Losing cs or my_turn here does not abort: the RAM read is
                // already in flight and must be consumed.
                ST_READ: begin
                    if (sram_read_finish) begin
                        r_data_out <= mix_half(data_in, sram_data_in);
                        r_rd       <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sram_rd     = r_rd;
    assign sram_offset = r_offset;
    assign done        = r_done;
    assign data_out    = r_data_out;

endmodule

// File: tb/tb_chorus_effect.sv
// ---------------------------------------------------------------------------
// tb_chorus_effect
// Self-checking bench for chorus_effect. A RAM responder serves reads with
// random latency and pushes the expected (offset, mix) into a scoreboard;
// a monitor pops and compares on every done pulse and also checks the
// cycle timing of sram_rd and done against a simple protocol model.
// ---------------------------------------------------------------------------
module tb_chorus_effect;
    import fx_pkg::*;

    localparam int BASE  = 1024;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cs = 1'b0;
    logic        my_turn = 1'b0;
    logic [15:0] data_in = '0;
    logic [15:0] sram_data_in = '0;
    logic        sram_read_finish = 1'b0;
    logic        sram_rd;
    logic [12:0] sram_offset;
    logic        done;
    logic [15:0] data_out;

    always #5 clk = ~clk;

    chorus_effect #(
        .BASE_DELAY(BASE),
        .DEPTH     (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cs              (cs),
        .my_turn         (my_turn),
        .data_in         (data_in),
        .sram_data_in    (sram_data_in),
        .sram_read_finish(sram_read_finish),
        .sram_rd         (sram_rd),
        .sram_offset     (sram_offset),
        .done            (done),
        .data_out        (data_out)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int mem [8192];   // delay line; newest sample lives at index 8191
    int n_model = 0;  // operations issued since reset

    // Triangle wave 0..DEPTH..0 as a function of completed operations.
    function automatic int tri_lfo(input int k);
        int p;
        p = k % (2 * DEPTH);
        return (p <= DEPTH) ? p : 2 * DEPTH - p;
    endfunction

    function automatic logic [15:0] mix_ref(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        return 16'(s >>> 1);
    endfunction

    typedef struct {
        logic [12:0] off;
        logic [15:0] out;
    } exp_t;

    exp_t        sb[$];
    logic [12:0] log_off[$];
    logic [15:0] log_out[$];

    // responder configuration, set by the main sequence
    bit          use_fixed = 1'b1;
    logic [15:0] fixed_din = 16'd4;
    bit          force_ram = 1'b0;
    logic [15:0] forced_val = '0;
    int          min_lat = 0;
    int          max_lat = 5;
    bit          stray_req = 1'b0;

    // ---------------- RAM responder / stimulus ----------------
    logic [12:0] rsp_off;
    logic [15:0] rsp_val;
    int          rsp_lat;
    bit          rsp_abort;
    bit          rsp_stable;
    exp_t        rsp_e;

    initial begin
        forever begin
            @(negedge clk);
            if (stray_req) begin
                sram_data_in     = 16'h1234;
                sram_read_finish = 1'b1;
                @(negedge clk);
                sram_read_finish = 1'b0;
                stray_req        = 1'b0;
            end else if (rst && sram_rd) begin
                rsp_off = sram_offset;
                check("rd_offset", rsp_off, 13'(BASE + tri_lfo(n_model)));
                rsp_lat    = $urandom_range(max_lat, min_lat);
                rsp_abort  = 1'b0;
                rsp_stable = 1'b1;
                for (int i = 0; i < rsp_lat; i++) begin
                    @(negedge clk);
                    if (!rst) begin
                        rsp_abort = 1'b1;
                        break;
                    end
                    if (!sram_rd || sram_offset !== rsp_off) rsp_stable = 1'b0;
                end
                if (!rsp_abort) begin
                    check("rd_held_stable", 32'(rsp_stable), 32'd1);
                    rsp_val          = force_ram ? forced_val : 16'(mem[(8191 - int'(rsp_off)) & 8191]);
                    data_in          = use_fixed ? fixed_din : 16'($urandom);
                    sram_data_in     = rsp_val;
                    sram_read_finish = 1'b1;
                    rsp_e.off        = rsp_off;
                    rsp_e.out        = mix_ref(data_in, rsp_val);
                    sb.push_back(rsp_e);
                    n_model++;
                    @(negedge clk);
                    sram_read_finish = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    bit          fin_q, rd_q, idle_q;
    bit          exp_done, exp_rd;
    int          done_count = 0;
    logic [15:0] last_out = '0;
    exp_t        mon_e;

    // Sample pre-edge inputs/state to predict what the edge must produce.
    always @(posedge clk) begin
        if (!rst) begin
            fin_q  = 1'b0;
            rd_q   = 1'b0;
            idle_q = 1'b0;
        end else begin
            fin_q  = sram_read_finish;
            rd_q   = sram_rd;
            idle_q = !sram_rd && !done && cs && my_turn;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            exp_done = rd_q && fin_q;
            exp_rd   = (rd_q && !fin_q) || idle_q;
            if (done || exp_done) check("done_timing", 32'(done), 32'(exp_done));
            if (sram_rd || exp_rd) check("rd_timing", 32'(sram_rd), 32'(exp_rd));
            if (done) begin
                done_count++;
                log_off.push_back(sram_offset);
                log_out.push_back(data_out);
                if (sb.size() == 0) begin
                    check("sb_unexpected_done", 32'(sb.size()), 32'd1);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_offset", sram_offset, mon_e.off);
                    check("out_data", data_out, mon_e.out);
                    last_out = mon_e.out;
                end
            end else begin
                check("out_hold", data_out, last_out);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_dones(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done_count >= target) return;
        end
        check("done_timeout", done_count, target);
    endtask

    task automatic wait_rd(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (sram_rd) return;
        end
        check("rd_timeout", 32'(sram_rd), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    logic [12:0] exp_wrap [6];
    logic [15:0] corner_din [3];
    logic [15:0] corner_ram [3];
    logic [15:0] corner_exp [3];
    int          cnt_rd, cnt_done;

    initial begin
        exp_wrap   = '{13'd1024, 13'd1025, 13'd1026, 13'd1025, 13'd1024, 13'd1025};
        corner_din = '{16'h8000, 16'h7FFF, 16'hFFFD};
        corner_ram = '{16'h8000, 16'h7FFF, 16'h0000};
        corner_exp = '{16'h8000, 16'h7FFF, 16'hFFFE};
        for (int i = 0; i < 8192; i++) mem[i] = i;

        // reset state
        repeat (3) @(negedge clk);
        check("reset_rd", 32'(sram_rd), 32'd0);
        check("reset_offset", sram_offset, 13'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_data_out", data_out, 16'd0);

        // ramp RAM, data_in=4: LFO wrap sequence and known mixes
        rst     = 1'b1;
        cs      = 1'b1;
        my_turn = 1'b1;
        wait_dones(6, 200);
        for (int i = 0; i < 6; i++) check("wrap_offset", log_off[i], exp_wrap[i]);
        check("ramp_out0", log_out[0], 16'd3585);
        check("ramp_out1", log_out[1], 16'd3585);
        check("ramp_out2", log_out[2], 16'd3584);

        // randomized phase: random RAM contents, data, enables and latency
        for (int i = 0; i < 8192; i++) mem[i] = int'($urandom_range(65535, 0));
        use_fixed = 1'b0;
        repeat (600) begin
            @(negedge clk);
            my_turn = ($urandom_range(3, 0) != 0);
            cs      = ($urandom_range(7, 0) != 0);
        end

        // signed mixing corners
        cs        = 1'b1;
        my_turn   = 1'b1;
        use_fixed = 1'b1;
        force_ram = 1'b1;
        wait_dones(done_count + 1, 60);
        for (int i = 0; i < 3; i++) begin
            fixed_din  = corner_din[i];
            forced_val = corner_ram[i];
            wait_dones(done_count + 1, 60);
            check("corner_out", log_out[$], corner_exp[i]);
        end

        // slow read with my_turn and cs dropped mid-read
        min_lat = 5;
        max_lat = 5;
        wait_dones(done_count + 1, 60);
        wait_rd(20);
        my_turn = 1'b0;
        cs      = 1'b0;
        cnt_done = done_count;
        wait_dones(cnt_done + 1, 20);
        check("dropped_turn_done", done_count, cnt_done + 1);

        // disabled block: no activity, stray finish ignored
        my_turn  = 1'b1;
        cnt_rd   = 0;
        cnt_done = 0;
        repeat (50) begin
            @(negedge clk);
            if (cnt_rd + cnt_done == 0 && $time > 0) cnt_rd += int'(sram_rd);
            cnt_done += int'(done);
            if (n_checks % 7 == 3) stray_req = 1'b1;
        end
        stray_req = 1'b1;
        repeat (4) begin
            @(negedge clk);
            cnt_done += int'(done);
            cnt_rd   += int'(sram_rd);
        end
        check("cs_low_rd", cnt_rd, 0);
        check("cs_low_done", cnt_done, 0);

        // reset in the middle of a read
        force_ram = 1'b0;
        fixed_din = 16'd4;
        for (int i = 0; i < 8192; i++) mem[i] = i;
        cs = 1'b1;
        wait_rd(20);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midreset_rd", 32'(sram_rd), 32'd0);
        check("midreset_offset", sram_offset, 13'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_data_out", data_out, 16'd0);
        sb.delete();
        n_model  = 0;
        last_out = '0;
        min_lat  = 0;
        max_lat  = 5;
        repeat (2) @(negedge clk);
        rst      = 1'b1;
        cnt_done = done_count;
        wait_dones(cnt_done + 1, 40);
        check("post_reset_offset", log_off[$], 13'd1024);
        check("post_reset_out", log_out[$], 16'd3585);

        // drain
        my_turn = 1'b0;
        cs      = 1'b0;
        repeat (20) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
